// File: rtl/rtc_bus_arbiter_if.sv
// RTC bus arbiter signal bundle: requester command/handshake side plus the
// multiplexed address/data pad side. The arbiter uses the slave modport.
interface rtc_bus_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  rnw;
  logic [23:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [7:0]  rdata;
  logic        busy;
  logic        cs_n;
  logic        rd_n;
  logic        wr_n;
  logic        a_d;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  ad_in;

  modport slave (
    input  req, rnw, addr, wdata, ad_in,
    output gnt, done, rdata, busy, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe
  );

  modport master (
    output req, rnw, addr, wdata, ad_in,
    input  gnt, done, rdata, busy, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Three-way arbiter and bus-cycle generator for the multiplexed RTC bus.
// Optional RTC_ARB_ROUND_ROBIN_EN alternates write/read when both are pending.
module rtc_bus_arbiter #(
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_GAP   = 2,
  parameter int unsigned CNT_W   = 4
) (
  input logic             clk,
  input logic             reset,
  rtc_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_GAP, DATA, DATA_GAP, DONE} state_t;

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(T_GAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       gnt_q, gnt_d, done_q, done_d;
  logic             rnw_q, rnw_d;
  logic [7:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic             busy_q, busy_d, cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic             a_d_q, a_d_d, ad_oe_q, ad_oe_d;
  logic [7:0]       ad_out_q, ad_out_d;
  logic [2:0]       win_oh;
  logic             sel_rnw;
  logic [7:0]       sel_addr, sel_wdata;
`ifdef RTC_ARB_ROUND_ROBIN_EN
  logic             fav_wr_q, fav_wr_d;
`endif

  // Init always wins; write/read tie broken by fixed order or by the pointer.
  always_comb begin
    win_oh    = 3'b100;
    sel_rnw   = bus.rnw[2];
    sel_addr  = bus.addr[23:16];
    sel_wdata = bus.wdata[23:16];
    if (bus.req[0]) begin
      win_oh    = 3'b001;
      sel_rnw   = bus.rnw[0];
      sel_addr  = bus.addr[7:0];
      sel_wdata = bus.wdata[7:0];
`ifdef RTC_ARB_ROUND_ROBIN_EN
    end else if (bus.req[1] && (!bus.req[2] || fav_wr_q)) begin
`else
    end else if (bus.req[1]) begin
`endif
      win_oh    = 3'b010;
      sel_rnw   = bus.rnw[1];
      sel_addr  = bus.addr[15:8];
      sel_wdata = bus.wdata[15:8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef RTC_ARB_ROUND_ROBIN_EN
    fav_wr_d = fav_wr_q;
`endif
    unique case (state_q)
      IDLE: if (|bus.req) begin
        state_d = ADDR;
        cnt_d   = PULSE_LD;
        gnt_d   = win_oh;
        rnw_d   = sel_rnw;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
      end
      ADDR: if (cnt_q == '0) begin
        state_d = ADDR_GAP;
        cnt_d   = GAP_LD;
      end else cnt_d = cnt_q - CNT_W'(1);
      ADDR_GAP: if (cnt_q == '0) begin
        state_d = DATA;
        cnt_d   = PULSE_LD;
      end else cnt_d = cnt_q - CNT_W'(1);
      DATA: if (cnt_q == '0) begin
        state_d = DATA_GAP;
        cnt_d   = GAP_LD;
        if (rnw_q) rdata_d = bus.ad_in;
      end else cnt_d = cnt_q - CNT_W'(1);
      DATA_GAP: if (cnt_q == '0) state_d = DONE;
      else cnt_d = cnt_q - CNT_W'(1);
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
`ifdef RTC_ARB_ROUND_ROBIN_EN
        if (gnt_q[1]) fav_wr_d = 1'b0;
        else if (gnt_q[2]) fav_wr_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad outputs are decoded from the next state so they register with it.
  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    a_d_d    = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = ad_out_q;
    done_d   = '0;
    busy_d   = (state_d != IDLE);
    unique case (state_d)
      ADDR: begin
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        a_d_d    = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      ADDR_GAP: begin
        a_d_d   = 1'b0;
        ad_oe_d = 1'b1;
      end
      DATA: begin
        cs_n_d = 1'b0;
        if (rnw_d) rd_n_d = 1'b0;
        else begin
          wr_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end
      end
      DONE:    done_d = gnt_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a_d_q    <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_out_q <= '0;
`ifdef RTC_ARB_ROUND_ROBIN_EN
      fav_wr_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      a_d_q    <= a_d_d;
      ad_oe_q  <= ad_oe_d;
      ad_out_q <= ad_out_d;
`ifdef RTC_ARB_ROUND_ROBIN_EN
      fav_wr_q <= fav_wr_d;
`endif
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
  assign bus.cs_n   = cs_n_q;
  assign bus.rd_n   = rd_n_q;
  assign bus.wr_n   = wr_n_q;
  assign bus.a_d    = a_d_q;
  assign bus.ad_out = ad_out_q;
  assign bus.ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Scoreboard bench for rtc_bus_arbiter: predicted transactions are queued by
// the stimulus, a negedge monitor checks every bus cycle and done pulse.
module tb_rtc_bus_arbiter;
  localparam int unsigned TP  = 4;
  localparam int unsigned TG  = 2;
  localparam int unsigned LAT = 2 * (TP + TG);

  typedef struct {
    int unsigned idx;
    logic        rnw;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } txn_t;

  logic clk, reset;
  rtc_bus_arbiter_if bus ();

  rtc_bus_arbiter #(.T_PULSE(TP), .T_GAP(TG), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int unsigned n_tests = 0, n_fail = 0;
  txn_t        sb[$];
  logic [7:0]  rd_val[3];
  logic [7:0]  last_rd = 8'h00;
  bit          fav_w = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbitration rule applied to a set of pending requesters.
  function automatic int unsigned pick(input logic [2:0] pend);
    if (pend[0]) return 0;
`ifdef RTC_ARB_ROUND_ROBIN_EN
    if (pend[1] && pend[2]) return fav_w ? 1 : 2;
`endif
    if (pend[1]) return 1;
    return 2;
  endfunction

  task automatic push(input int unsigned k);
    txn_t e;
    e.idx   = k;
    e.rnw   = bus.rnw[k];
    e.addr  = bus.addr[8*k +: 8];
    e.wdata = bus.wdata[8*k +: 8];
    if (e.rnw) last_rd = rd_val[k];
    e.rdata = last_rd;
    if (k == 1) fav_w = 1'b0;
    if (k == 2) fav_w = 1'b1;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (sb.size() == 0 && !bus.busy && bus.req == 3'b000) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check(ok, name, sb.size(), 0);
    if (!ok) begin
      bus.req = '0;
      sb.delete();
    end
  endtask

  // All requesters in sub raise together and each drops on its own done.
  task automatic episode(input logic [2:0] sub, input logic [2:0] rnw_v,
                         input logic [23:0] a_v, input logic [23:0] w_v,
                         input logic [23:0] r_v, input bit scr);
    logic [2:0] pend;
    bus.rnw = rnw_v;
    bus.addr = a_v;
    bus.wdata = w_v;
    for (int k = 0; k < 3; k++) rd_val[k] = r_v[8*k +: 8];
    pend = sub;
    while (pend != 3'b000) begin
      int unsigned k;
      k = pick(pend);
      push(k);
      pend[k] = 1'b0;
    end
    bus.req = sub;
    for (int c = 0; c < 300 && bus.req != 3'b000; c++) begin
      @(posedge clk); #1;
      if (scr) begin
        for (int k = 0; k < 3; k++)
          if (bus.gnt[k]) begin
            bus.rnw[k] = 1'($urandom);
            bus.addr[8*k +: 8] = 8'($urandom);
            bus.wdata[8*k +: 8] = 8'($urandom);
          end
      end
      bus.req = bus.req & ~bus.done;
    end
    wait_drain("episode_drain");
  endtask

  // Pad model: correct read data only during the final read-strobe cycle.
  initial begin
    int unsigned lo = 0;
    int unsigned g;
    logic [7:0] r;
    bus.ad_in = 8'h00;
    forever begin
      @(negedge clk);
      lo = bus.rd_n ? 0 : lo + 1;
      g = bus.gnt[2] ? 2 : (bus.gnt[1] ? 1 : 0);
      r = 8'($urandom);
      if (r == rd_val[g]) r = r ^ 8'h01;
      bus.ad_in = (lo == TP) ? rd_val[g] : r;
    end
  end

  // Monitor: compares every cycle of a granted transaction with the timeline.
  initial begin
    txn_t cur;
    bit in_txn = 1'b0, post_done = 1'b0, wave_ok = 1'b1;
    int unsigned t = 0, ph;
    logic [2:0] oh;
    logic [19:0] act, exp, msk, bad_act, bad_exp;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_txn = 1'b0;
        post_done = 1'b0;
      end else begin
        if (post_done) begin
          check({bus.gnt, bus.done, bus.busy, bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe}
                == 14'b000_000_0_1111_0, "idle_after_done",
                {bus.gnt, bus.done, bus.busy, bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe},
                14'b000_000_0_1111_0);
          post_done = 1'b0;
        end
        if (!in_txn && bus.gnt != 3'b000) begin
          if (sb.size() == 0) check(1'b0, "unexpected_grant", bus.gnt, 0);
          else begin
            cur = sb[0];
            oh = 3'(1 << cur.idx);
            check(bus.gnt == oh, "grant", bus.gnt, oh);
            in_txn = 1'b1;
            t = 0;
            wave_ok = 1'b1;
          end
        end
        if (in_txn) begin
          ph = (t < TP) ? 0 : (t < TP + TG) ? 1 : (t < 2*TP + TG) ? 2 : (t < LAT) ? 3 : 4;
          act = {bus.gnt, bus.done, bus.busy, bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d,
                 bus.ad_oe, bus.ad_out};
          exp = {oh, (ph == 4) ? oh : 3'b000, 1'b1,
                 !(ph == 0 || ph == 2), !(ph == 2 && cur.rnw),
                 !(ph == 0 || (ph == 2 && !cur.rnw)), ph >= 2,
                 ph <= 1 || (ph == 2 && !cur.rnw), (ph <= 1) ? cur.addr : cur.wdata};
          msk = {3'b111, 3'b111, 1'b1, 3'b111, (ph == 0 || ph == 2), 1'b1,
                 (ph <= 1 || (ph == 2 && !cur.rnw)) ? 8'hFF : 8'h00};
          if (wave_ok && ((act ^ exp) & msk) != 20'h0) begin
            wave_ok = 1'b0;
            bad_act = act & msk;
            bad_exp = exp & msk;
          end
          if (bus.done != 3'b000) begin
            check(bus.done == oh, "done_onehot", bus.done, oh);
            check(t == LAT, "latency", t, LAT);
            check(wave_ok, "waveform", bad_act, bad_exp);
            check(bus.rdata == cur.rdata, "rdata", bus.rdata, cur.rdata);
            void'(sb.pop_front());
            in_txn = 1'b0;
            post_done = 1'b1;
          end else if (t > LAT + 2) begin
            check(bus.done != 3'b000, "done_timeout", bus.done, oh);
            void'(sb.pop_front());
            in_txn = 1'b0;
          end
          t++;
        end else if (bus.done != 3'b000) begin
          check(1'b0, "unexpected_done", bus.done, 0);
        end
      end
    end
  end

  initial begin
    bit found;
    int unsigned nd;
    bus.req = '0;
    bus.rnw = '0;
    bus.addr = '0;
    bus.wdata = '0;
    for (int k = 0; k < 3; k++) rd_val[k] = 8'h00;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check({bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe, bus.busy, bus.gnt, bus.done,
           bus.ad_out, bus.rdata} == {4'hF, 2'b00, 6'h00, 16'h0000}, "reset_state",
          {bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe, bus.busy, bus.gnt, bus.done,
           bus.ad_out, bus.rdata}, {4'hF, 2'b00, 6'h00, 16'h0000});
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;

    episode(3'b010, 3'b000, 24'h002100, 24'h004500, 24'h0, 1'b0);
    episode(3'b100, 3'b100, 24'h220000, 24'h000000, 24'h590000, 1'b0);
    episode(3'b111, 3'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 1'b0);
    for (int i = 0; i < 30; i++)
      episode(3'($urandom_range(1, 7)), 3'($urandom), 24'($urandom), 24'($urandom),
              24'($urandom), 1'b1);

    // Asynchronous reset in the middle of a write data phase.
    bus.rnw = 3'b000;
    bus.addr = 24'($urandom);
    bus.wdata = 24'($urandom);
    push(1);
    bus.req = 3'b010;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.busy && !bus.cs_n && bus.a_d && !bus.wr_n) begin
        found = 1'b1;
        break;
      end
    end
    check(found, "reach_data_phase", found, 1);
    #2 reset = 1'b1;
    #1;
    check({bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe, bus.gnt, bus.done, bus.busy}
          == 11'b111_0_000_000_0, "reset_mid_txn",
          {bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe, bus.gnt, bus.done, bus.busy},
          11'b111_0_000_000_0);
    bus.req = '0;
    sb.delete();
    last_rd = 8'h00;
    fav_w = 1'b1;
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // Write and read held high together across four transactions.
    bus.rnw = 3'b100;
    bus.addr = 24'($urandom);
    bus.wdata = 24'($urandom);
    for (int k = 0; k < 3; k++) rd_val[k] = 8'($urandom);
    for (int i = 0; i < 4; i++) push(pick(3'b110));
    bus.req = 3'b110;
    nd = 0;
    for (int c = 0; c < 300 && nd < 4; c++) begin
      @(posedge clk); #1;
      if (bus.done != 3'b000) nd++;
    end
    bus.req = '0;
    wait_drain("hold_drain");

    // Request withdrawn during the address gap still completes.
    bus.rnw = 3'b000;
    bus.addr = 24'($urandom);
    bus.wdata = 24'($urandom);
    push(1);
    bus.req = 3'b010;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.busy && bus.cs_n && !bus.a_d && bus.ad_oe) begin
        found = 1'b1;
        break;
      end
    end
    check(found, "reach_addr_gap", found, 1);
    bus.req = '0;
    wait_drain("drop_drain");

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Shares the single address/data-multiplexed RTC bus between three requesters: init sequencer, edit/write FSM and periodic read/refresh FSM.
- Arbitrates, latches the winner's command, then generates the full bus cycle: address phase, gap, data phase (read or write), gap.
- Returns a one-cycle done pulse and, for reads, the captured data.
- Sits between the control FSMs and the RTC pad drivers.

Parameters:
- T_PULSE, 4, strobe-low width in clk cycles for each phase; minimum 1.
- T_GAP, 2, strobes-high recovery cycles after each phase; minimum 1.
- CNT_W, 4, phase counter width; must satisfy 2^CNT_W > max(T_PULSE, T_GAP).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- req  in  3  request; bit0 init, bit1 write FSM, bit2 read FSM.
- rnw  in  3  per-requester direction; 1 = read, 0 = write.
- addr  in  24  per-requester register address, 8 bits each; requester k uses bits [8k+7:8k].
- wdata  in  24  per-requester write data, same packing as addr.
- gnt  out  3  one-hot; high from grant edge through the done cycle.
- done  out  3  one-hot, one-cycle pulse at transaction end.
- rdata  out  8  read data, valid from the done cycle until the next read completes.
- busy  out  1  high in every state except IDLE.
- cs_n, rd_n, wr_n  out  1 each  RTC bus strobes, active-low.
- a_d  out  1  0 = address phase, 1 = data phase.
- ad_out  out  8  bus drive value.
- ad_oe  out  1  pad output enable.
- ad_in  in  8  bus sampled value.

Behaviour:
- Reset values:
  - cs_n = rd_n = wr_n = a_d = 1.
  - ad_out = 0x00, ad_oe = 0, gnt = 0, done = 0, rdata = 0x00, busy = 0, state IDLE, priority pointer → write.
- All outputs are registered.
- States: IDLE, ADDR, ADDR_GAP, DATA, DATA_GAP, DONE.
- IDLE:
  - Samples req each edge. If any bit is set, selects the winner (fixed priority init > write > read).
  - Latches the winner's rnw, addr and wdata, sets the gnt bit, and goes to ADDR.
- ADDR (T_PULSE cycles):
  - cs_n = 0, a_d = 0, wr_n = 0, ad_oe = 1, ad_out = latched addr.
  - This is an address write cycle regardless of rnw.
- ADDR_GAP (T_GAP cycles): cs_n = wr_n = 1; ad_oe stays 1 and ad_out holds addr (hold time).
- DATA (T_PULSE cycles): cs_n = 0, a_d = 1.
  - Write: wr_n = 0, ad_oe = 1, ad_out = wdata.
  - Read: rd_n = 0, ad_oe = 0; ad_in is captured into rdata on the last DATA cycle.
- DATA_GAP (T_GAP cycles):
  - Strobes high; ad_oe falls to 0 on entry for both directions.
  - a_d returns to 1 in IDLE.
- DONE (1 cycle): done bit = gnt bit; next edge goes to IDLE and gnt clears.
- Latency: done is high in the cycle beginning 2*(T_PULSE+T_GAP) edges after the grant edge. Defaults: 12 edges; bus is occupied for 13 cycles including DONE.
- Requests are ignored outside IDLE. A req dropped mid-transaction does not abort it; done still pulses.
- Requester rule: deassert req on the edge where done is seen. The arbiter samples again one cycle after DONE, so a req still high then starts a new transaction.
- rnw/addr/wdata changes after grant have no effect.
- Simultaneous requests: exactly one gnt bit; losers are served in later transactions.
- Async reset mid-transaction: strobes and ad_oe return to their idle values immediately, with no done pulse. The RTC sees a truncated cycle, and the requesters restart after reset.
- Phase counter: loads T_PULSE-1 or T_GAP-1 on phase entry and counts down to 0.

Optional Feature:
- Macro: RTC_ARB_ROUND_ROBIN_EN.
- Defined: init keeps absolute priority. When write and read are both pending, the one not served last wins. The pointer updates only on DONE of a write or read transaction, and resets to favour write.
- Undefined: fixed priority init > write > read; no pointer logic.

Test Plan:
- Write: req[1], rnw=0, addr 0x21, wdata 0x45 → ADDR phase wr_n low 4 cycles with ad_out 0x21, a_d 0; DATA phase wr_n low 4 cycles with ad_out 0x45, a_d 1; done[1] pulses 12 edges after grant; rdata unchanged.
- Read: req[2], rnw=1, addr 0x22, bench drives ad_in 0x59 → rd_n low 4 cycles, ad_oe 0 during DATA, rdata = 0x59 at done[2]; wr_n low only in ADDR.
- All three req raised in the same cycle → grants init, then write, then read in consecutive transactions; gnt is always one-hot.
- Write and read held continuously high → fixed priority gives write every time and the read is never granted. With RTC_ARB_ROUND_ROBIN_EN: write, read, write, read.
- reset pulsed during DATA of a write → cs_n/wr_n = 1, ad_oe = 0, gnt = 0 immediately; no done; after release, IDLE and a fresh req is served normally.
- req[1] dropped in ADDR_GAP → transaction completes with the full DATA phase and done[1] still pulses.
